// File: rtl/serdes_recv_ctrl.sv
// serdes_recv_ctrl -- receive-side deframer for the 4-lane SerDes link.
//
// Merges four 16-bit lanes into one 64-bit word W = {rx4,rx3,rx2,rx1} and
// tracks the 3-word stream header (1c/3c/5c = I/Q stream, 1c/3c/7c = energy
// stream).
//   I/Q stream: 48-bit samples packed 4 per 3 words, delivered on two slots.
//   Energy stream: each payload word is one target record.
// Lane input to enable/data output is 2 cycles: the stage-1 input register,
// then the registered outputs. There is no backpressure.
//
// Ports
//   I_sys_clk, I_rst            clock, asynchronous active-high reset
//   I_rxN_is_k, I_rxN_serdes_dat  per-lane flag (1 = payload) and data, N=1..4
//   O_iq0_ena, O_i0_dat, O_q0_dat   slot-0 sample (every I/Q payload word)
//   O_iq1_ena, O_i1_dat, O_q1_dat   slot-1 sample (the later one, phase 2 only)
//   O_target_ena + record fields    energy record
//   O_stream_mode                   0 none, 1 I/Q, 2 energy
//   O_lane_err/O_align_err/O_fmt_err  single-cycle error pulses
// Optional feature, macro SERDES_RX_ERR_CNT_EN: saturating error counters
//   O_*_err_cnt plus synchronous clear input I_err_cnt_clr.
module serdes_recv_ctrl #(
    parameter int          SAMPLE_W  = 24,  // unpacking slices assume 24
    parameter int          ERR_CNT_W = 16,
    parameter logic [63:0] IDLE_WORD = 64'hc5bc_c5bc_c5bc_c5bc
) (
    input  logic                 I_sys_clk,
    input  logic                 I_rst,
`ifdef SERDES_RX_ERR_CNT_EN
    input  logic                 I_err_cnt_clr,
    output logic [ERR_CNT_W-1:0] O_lane_err_cnt,
    output logic [ERR_CNT_W-1:0] O_align_err_cnt,
    output logic [ERR_CNT_W-1:0] O_fmt_err_cnt,
`endif
    input  logic                 I_rx1_is_k,
    input  logic                 I_rx2_is_k,
    input  logic                 I_rx3_is_k,
    input  logic                 I_rx4_is_k,
    input  logic [15:0]          I_rx1_serdes_dat,
    input  logic [15:0]          I_rx2_serdes_dat,
    input  logic [15:0]          I_rx3_serdes_dat,
    input  logic [15:0]          I_rx4_serdes_dat,
    output logic                 O_iq0_ena,
    output logic [SAMPLE_W-1:0]  O_i0_dat,
    output logic [SAMPLE_W-1:0]  O_q0_dat,
    output logic                 O_iq1_ena,
    output logic [SAMPLE_W-1:0]  O_i1_dat,
    output logic [SAMPLE_W-1:0]  O_q1_dat,
    output logic                 O_target_ena,
    output logic [15:0]          O_mach_angle,
    output logic [2:0]           O_mode,
    output logic [4:0]           O_angle,
    output logic [23:0]          O_target_energy,
    output logic [12:0]          O_target_range,
    output logic [1:0]           O_stream_mode,
    output logic                 O_lane_err,
    output logic                 O_align_err,
    output logic                 O_fmt_err
);
    localparam logic [63:0] HDR1 = 64'h1c1c_1c1c_1c1c_1c1c;
    localparam logic [63:0] HDR3 = 64'h3c3c_3c3c_3c3c_3c3c;
    localparam logic [63:0] HDR5 = 64'h5c5c_5c5c_5c5c_5c5c;
    localparam logic [63:0] HDR7 = 64'h7c7c_7c7c_7c7c_7c7c;

    typedef enum logic [2:0] {S_HUNT, S_H1, S_H2, S_IQ, S_EN} state_t;

    // Stage 1: registered lanes and flags
    logic [63:0] word_q;
    logic [3:0]  k_q;

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            word_q <= '0;
            k_q    <= '0;
        end else begin
            word_q <= {I_rx4_serdes_dat, I_rx3_serdes_dat, I_rx2_serdes_dat, I_rx1_serdes_dat};
            k_q    <= {I_rx4_is_k, I_rx3_is_k, I_rx2_is_k, I_rx1_is_k};
        end
    end

    logic is_pay, is_ctl, lane_mix;
    assign is_pay   = &k_q;
    assign is_ctl   = ~|k_q;
    assign lane_mix = !is_pay && !is_ctl;

    // FSM process 1: state register
    state_t state_q, state_d;

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) state_q <= S_HUNT;
        else       state_q <= state_d;
    end

    // FSM process 2: next state. Mixed-flag words fall through both branches
    // and leave the state untouched. Idle and unknown control words only
    // matter while a header is in progress.
    always_comb begin
        state_d = state_q;
        if (is_ctl) begin
            if (word_q == HDR1) begin
                state_d = S_H1;
            end else begin
                case (state_q)
                    S_H1:    state_d = (word_q == HDR3) ? S_H2 : S_HUNT;
                    S_H2:    state_d = (word_q == HDR5) ? S_IQ :
                                       (word_q == HDR7) ? S_EN : S_HUNT;
                    default: state_d = state_q;
                endcase
            end
        end else if (is_pay) begin
            if (state_q == S_H1 || state_q == S_H2) state_d = S_HUNT;
        end
    end

    // FSM process 3: output / datapath next values
    logic [1:0]          phase_q, phase_d;
    logic [31:0]         residue_q, residue_d;
    logic [47:0]         slot0;
    logic                iq0_ena_d, iq1_ena_d, tgt_ena_d;
    logic [SAMPLE_W-1:0] i0_d, q0_d, i1_d, q1_d;
    logic [15:0]         mach_d;
    logic [2:0]          mode_d;
    logic [4:0]          angle_d;
    logic [23:0]         energy_d;
    logic [12:0]         range_d;
    logic [1:0]          stream_mode_d;
    logic                lane_err_d, align_err_d, fmt_err_d;

    always_comb begin
        phase_d     = phase_q;
        residue_d   = residue_q;
        slot0       = '0;
        iq0_ena_d   = 1'b0;
        iq1_ena_d   = 1'b0;
        tgt_ena_d   = 1'b0;
        i0_d        = O_i0_dat;
        q0_d        = O_q0_dat;
        i1_d        = O_i1_dat;
        q1_d        = O_q1_dat;
        mach_d      = O_mach_angle;
        mode_d      = O_mode;
        angle_d     = O_angle;
        energy_d    = O_target_energy;
        range_d     = O_target_range;
        lane_err_d  = lane_mix;
        align_err_d = 1'b0;
        fmt_err_d   = 1'b0;

        case (state_q)
            S_IQ:    stream_mode_d = 2'd1;
            S_EN:    stream_mode_d = 2'd2;
            default: stream_mode_d = 2'd0;
        endcase

        if (is_ctl && word_q == HDR1) begin
            // A header cutting a partly-filled sample group loses the residue
            align_err_d = (state_q == S_IQ) && (phase_q != 2'd0);
            phase_d     = 2'd0;
            residue_d   = '0;
        end else if (is_pay && state_q == S_IQ) begin
            iq0_ena_d = 1'b1;
            case (phase_q)
                2'd0: begin
                    slot0     = word_q[63:16];
                    residue_d = {16'h0, word_q[15:0]};
                    phase_d   = 2'd1;
                end
                2'd1: begin
                    slot0     = {residue_q[15:0], word_q[63:32]};
                    residue_d = word_q[31:0];
                    phase_d   = 2'd1 + 2'd1;
                end
                default: begin
                    slot0     = {residue_q, word_q[63:48]};
                    iq1_ena_d = 1'b1;
                    i1_d      = word_q[47:24];
                    q1_d      = word_q[23:0];
                    residue_d = '0;
                    phase_d   = 2'd0;
                end
            endcase
            i0_d = slot0[47:24];
            q0_d = slot0[23:0];
        end else if (is_pay && state_q == S_EN) begin
            tgt_ena_d = 1'b1;
            mach_d    = word_q[63:48];
            mode_d    = word_q[47:45];
            angle_d   = word_q[44:40];
            energy_d  = word_q[39:16];
            range_d   = word_q[12:0];
            fmt_err_d = (word_q[15:13] != 3'd0);
        end
    end

    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            phase_q         <= '0;
            residue_q       <= '0;
            O_iq0_ena       <= 1'b0;
            O_iq1_ena       <= 1'b0;
            O_target_ena    <= 1'b0;
            O_i0_dat        <= '0;
            O_q0_dat        <= '0;
            O_i1_dat        <= '0;
            O_q1_dat        <= '0;
            O_mach_angle    <= '0;
            O_mode          <= '0;
            O_angle         <= '0;
            O_target_energy <= '0;
            O_target_range  <= '0;
            O_stream_mode   <= '0;
            O_lane_err      <= 1'b0;
            O_align_err     <= 1'b0;
            O_fmt_err       <= 1'b0;
        end else begin
            phase_q         <= phase_d;
            residue_q       <= residue_d;
            O_iq0_ena       <= iq0_ena_d;
            O_iq1_ena       <= iq1_ena_d;
            O_target_ena    <= tgt_ena_d;
            O_i0_dat        <= i0_d;
            O_q0_dat        <= q0_d;
            O_i1_dat        <= i1_d;
            O_q1_dat        <= q1_d;
            O_mach_angle    <= mach_d;
            O_mode          <= mode_d;
            O_angle         <= angle_d;
            O_target_energy <= energy_d;
            O_target_range  <= range_d;
            O_stream_mode   <= stream_mode_d;
            O_lane_err      <= lane_err_d;
            O_align_err     <= align_err_d;
            O_fmt_err       <= fmt_err_d;
        end
    end

`ifdef SERDES_RX_ERR_CNT_EN
    // Counters step with the pulse itself, so each count lines up with its pulse
    always_ff @(posedge I_sys_clk or posedge I_rst) begin
        if (I_rst) begin
            O_lane_err_cnt  <= '0;
            O_align_err_cnt <= '0;
            O_fmt_err_cnt   <= '0;
        end else if (I_err_cnt_clr) begin
            O_lane_err_cnt  <= '0;
            O_align_err_cnt <= '0;
            O_fmt_err_cnt   <= '0;
        end else begin
            if (lane_err_d && !(&O_lane_err_cnt))
                O_lane_err_cnt <= O_lane_err_cnt + ERR_CNT_W'(1);
            if (align_err_d && !(&O_align_err_cnt))
                O_align_err_cnt <= O_align_err_cnt + ERR_CNT_W'(1);
            if (fmt_err_d && !(&O_fmt_err_cnt))
                O_fmt_err_cnt <= O_fmt_err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_serdes_recv_ctrl.sv
module tb_serdes_recv_ctrl;
  localparam logic [63:0] IDLE = 64'hc5bc_c5bc_c5bc_c5bc;
  localparam logic [63:0] H1   = 64'h1c1c_1c1c_1c1c_1c1c;
  localparam logic [63:0] H3   = 64'h3c3c_3c3c_3c3c_3c3c;
  localparam logic [63:0] H5   = 64'h5c5c_5c5c_5c5c_5c5c;
  localparam logic [63:0] H7   = 64'h7c7c_7c7c_7c7c_7c7c;
  localparam logic [63:0] WA   = 64'h1111_1122_2222_3333;
  localparam logic [63:0] WB   = 64'h3344_4444_5555_5566;
  localparam logic [63:0] WC   = 64'h6666_7777_7788_8888;

  logic        clk, rst;
  logic        k1, k2, k3, k4;
  logic [15:0] d1, d2, d3, d4;
  logic        iq0_ena, iq1_ena, tgt_ena;
  logic [23:0] i0, q0, i1, q1;
  logic [15:0] mach;
  logic [2:0]  mode;
  logic [4:0]  angle;
  logic [23:0] energy;
  logic [12:0] rng;
  logic [1:0]  smode;
  logic        lane_err, align_err, fmt_err;
`ifdef SERDES_RX_ERR_CNT_EN
  logic        cnt_clr;
  logic [15:0] lane_cnt, align_cnt, fmt_cnt;
`endif

  serdes_recv_ctrl dut (
    .I_sys_clk(clk), .I_rst(rst),
`ifdef SERDES_RX_ERR_CNT_EN
    .I_err_cnt_clr(cnt_clr), .O_lane_err_cnt(lane_cnt),
    .O_align_err_cnt(align_cnt), .O_fmt_err_cnt(fmt_cnt),
`endif
    .I_rx1_is_k(k1), .I_rx2_is_k(k2), .I_rx3_is_k(k3), .I_rx4_is_k(k4),
    .I_rx1_serdes_dat(d1), .I_rx2_serdes_dat(d2),
    .I_rx3_serdes_dat(d3), .I_rx4_serdes_dat(d4),
    .O_iq0_ena(iq0_ena), .O_i0_dat(i0), .O_q0_dat(q0),
    .O_iq1_ena(iq1_ena), .O_i1_dat(i1), .O_q1_dat(q1),
    .O_target_ena(tgt_ena), .O_mach_angle(mach), .O_mode(mode), .O_angle(angle),
    .O_target_energy(energy), .O_target_range(rng), .O_stream_mode(smode),
    .O_lane_err(lane_err), .O_align_err(align_err), .O_fmt_err(fmt_err)
  );

  // clock / reset block
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int issue_cyc = 0;

  // scoreboard: expected data and expected arrival cycle per output
  logic [47:0] exp_iq0_q[$];
  logic [47:0] exp_iq1_q[$];
  logic [61:0] exp_tgt_q[$];
  int          cyc_iq0_q[$];
  int          cyc_iq1_q[$];
  int          cyc_tgt_q[$];
  int          cyc_lane_q[$];
  int          cyc_align_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [3:0] k, input logic [63:0] w);
    @(negedge clk);
    {k4, k3, k2, k1} = k;
    {d4, d3, d2, d1} = w;
    issue_cyc = cyc;
  endtask

  task automatic send_ctl(input logic [63:0] w);
    send(4'h0, w);
  endtask

  task automatic send_pay(input logic [63:0] w);
    send(4'hf, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_ctl(IDLE);
  endtask

  task automatic push_iq0(input logic [23:0] ei, input logic [23:0] eq);
    exp_iq0_q.push_back({ei, eq});
    cyc_iq0_q.push_back(issue_cyc + 2);
  endtask

  task automatic push_iq1(input logic [23:0] ei, input logic [23:0] eq);
    exp_iq1_q.push_back({ei, eq});
    cyc_iq1_q.push_back(issue_cyc + 2);
  endtask

  task automatic push_tgt(input logic [61:0] rec);
    exp_tgt_q.push_back(rec);
    cyc_tgt_q.push_back(issue_cyc + 2);
  endtask

  task automatic iq_abc();
    send_pay(WA); push_iq0(24'h111111, 24'h222222);
    send_pay(WB); push_iq0(24'h333333, 24'h444444);
    send_pay(WC); push_iq0(24'h555555, 24'h666666); push_iq1(24'h777777, 24'h888888);
  endtask

  // monitor: pops and compares whenever the DUT presents an output
  always @(negedge clk) begin
    if (iq0_ena) begin
      if (exp_iq0_q.size() == 0) chk("iq0_unexpected", 64'(cyc), 64'd0);
      else begin
        chk("iq0_data", {16'h0, i0, q0}, {16'h0, exp_iq0_q.pop_front()});
        chk("iq0_cycle", 64'(cyc), 64'(cyc_iq0_q.pop_front()));
      end
    end
    if (iq1_ena) begin
      if (exp_iq1_q.size() == 0) chk("iq1_unexpected", 64'(cyc), 64'd0);
      else begin
        chk("iq1_data", {16'h0, i1, q1}, {16'h0, exp_iq1_q.pop_front()});
        chk("iq1_cycle", 64'(cyc), 64'(cyc_iq1_q.pop_front()));
      end
    end
    if (tgt_ena) begin
      if (exp_tgt_q.size() == 0) chk("tgt_unexpected", 64'(cyc), 64'd0);
      else begin
        chk("tgt_record", {2'b0, mach, mode, angle, energy, rng, fmt_err},
            {2'b0, exp_tgt_q.pop_front()});
        chk("tgt_cycle", 64'(cyc), 64'(cyc_tgt_q.pop_front()));
      end
    end
    if (fmt_err && !tgt_ena) chk("fmt_err_without_record", 64'd1, 64'd0);
    if (lane_err) begin
      if (cyc_lane_q.size() == 0) chk("lane_err_unexpected", 64'(cyc), 64'd0);
      else chk("lane_err_cycle", 64'(cyc), 64'(cyc_lane_q.pop_front()));
    end
    if (align_err) begin
      if (cyc_align_q.size() == 0) chk("align_err_unexpected", 64'(cyc), 64'd0);
      else chk("align_err_cycle", 64'(cyc), 64'(cyc_align_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1;
    {k4, k3, k2, k1} = 4'h0;
    {d4, d3, d2, d1} = IDLE;
`ifdef SERDES_RX_ERR_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_enables", {61'h0, iq0_ena, iq1_ena, tgt_ena}, 64'h0);
    chk("rst_iq_data", {16'h0, i0, q0} | {16'h0, i1, q1}, 64'h0);
    chk("rst_tgt_data", {2'h0, mach, mode, angle, energy, rng, 1'b0}, 64'h0);
    chk("rst_mode_errs", {59'h0, smode, lane_err, align_err, fmt_err}, 64'h0);
    rst = 1'b0;
    idle(2);

    // reset in the middle of a stream drops back to HUNT
    send_ctl(H1); send_ctl(H3); send_ctl(H5);
    send_pay(WA); push_iq0(24'h111111, 24'h222222);
    idle(3);
    chk("mode_iq_before_rst", 64'(smode), 64'd1);
    @(negedge clk); rst = 1'b1;
    #1 chk("mode_during_rst", 64'(smode), 64'd0);
    idle(2);
    rst = 1'b0;
    send_pay(WB);  // no header since reset: discarded
    idle(4);
    chk("mode_after_rst", 64'(smode), 64'd0);

    // I/Q stream, back-to-back words
    send_ctl(H1); send_ctl(H3); send_ctl(H5);
    iq_abc();
    chk("mode_iq", 64'(smode), 64'd1);
    idle(3);

    // energy stream: clean record, then one with nonzero format bits
    send_ctl(H1); send_ctl(H3); send_ctl(H7);
    send_pay(64'h1234_A5AB_CDEF_0FFF);
    push_tgt({16'h1234, 3'd5, 5'd5, 24'hABCDEF, 13'h0FFF, 1'b0});
    send_pay(64'hFFFF_FF00_0001_E001);
    push_tgt({16'hFFFF, 3'd7, 5'd31, 24'h000001, 13'h0001, 1'b1});
    idle(2);
    chk("mode_en", 64'(smode), 64'd2);
    idle(2);
    chk("hold_tgt_energy", 64'(energy), 64'h000001);

    // I/Q stream with idle gaps and lane-skewed words mid group
    send_ctl(H1); send_ctl(H3); send_ctl(H5);
    send_pay(WA); push_iq0(24'h111111, 24'h222222);
    idle(2);
    send_pay(WB); push_iq0(24'h333333, 24'h444444);
    for (int n = 0; n < 5; n++) begin
      send(4'b1011, 64'hdead_beef_0123_4567);
      cyc_lane_q.push_back(issue_cyc + 2);
    end
    send_pay(WC); push_iq0(24'h555555, 24'h666666); push_iq1(24'h777777, 24'h888888);
    idle(3);
    chk("hold_i1", {40'h0, i1}, 64'h777777);

    // truncated header returns to HUNT; following payload is dropped
    send_ctl(H1); send_ctl(H3); send_ctl(IDLE);
    send_pay(WA);
    idle(3);
    chk("mode_after_abort", 64'(smode), 64'd0);

    // header arriving mid group flags alignment, next stream starts at phase 0
    send_ctl(H1); send_ctl(H3); send_ctl(H5);
    send_pay(WA); push_iq0(24'h111111, 24'h222222);
    send_ctl(H1); cyc_align_q.push_back(issue_cyc + 2);
    send_ctl(H3); send_ctl(H5);
    iq_abc();
    idle(3);

`ifdef SERDES_RX_ERR_CNT_EN
    chk("lane_err_cnt", 64'(lane_cnt), 64'd5);
    chk("align_err_cnt", 64'(align_cnt), 64'd1);
    chk("fmt_err_cnt", 64'(fmt_cnt), 64'd1);
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    chk("cnt_clear", 64'(lane_cnt) | 64'(align_cnt) | 64'(fmt_cnt), 64'd0);
`endif

    // drain: every expected item must have been seen
    idle(4);
    chk("iq0_left", 64'(exp_iq0_q.size()), 64'd0);
    chk("iq1_left", 64'(exp_iq1_q.size()), 64'd0);
    chk("tgt_left", 64'(exp_tgt_q.size()), 64'd0);
    chk("lane_err_left", 64'(cyc_lane_q.size()), 64'd0);
    chk("align_err_left", 64'(cyc_align_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
